// File: rtl/tdc_event_collector_pkg.sv
// Shared types for the TDC event collector: channel id, event word, FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package TDCTypes;

  // Wide enough for the largest supported channel count (16).
  localparam int TDC_CHAN_W = 4;

  typedef logic [TDC_CHAN_W-1:0] TDC_CHANNEL;

  typedef struct packed {
    TDC_CHANNEL  chan;
    logic [31:0] timestamp;
    logic [31:0] tot;
  } tdc_event_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SETTLE = 2'd2
  } collector_state_e;

  // Build an event word from a channel index and the TDC's captured fields.
  function automatic tdc_event_t make_event(input TDC_CHANNEL chan,
                                            input logic [31:0] ts,
                                            input logic [31:0] tot_val);
    tdc_event_t ev;
    ev.chan      = chan;
    ev.timestamp = ts;
    ev.tot       = tot_val;
    return ev;
  endfunction

endpackage

// File: rtl/tdc_event_collector_fifo.sv
// First-word fall-through FIFO for collected TDC events, generic element type.
// Latency: a pushed word is visible on pop_dat_o right after the push edge.
// Backpressure: pushes are ignored while full; pops are ignored while empty.
module tdc_event_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  T                         push_dat_i,
  input  logic                     pop_i,
  output T                         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     level_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is not reset: a slot is only observable while level_q covers it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers wrap naturally (power-of-two depth); level_q tells full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Empty FIFO presents an all-zero word so the output is clean after reset.
  assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/tdc_event_collector.sv
// Round-robin collector of per-channel TDC events into a FWFT event FIFO; optional stall counter via TDC_COLLECTOR_STALL_CNT_EN.
// Latency: event granted at edge T is on evt_data right after T (empty FIFO); clear pulses T..T+1; one event per 3 cycles max.
// Backpressure: when the FIFO is full nothing is granted, events wait inside the TDCs; evt_valid/evt_data hold until evt_ready.
module tdc_event_collector
  import TDCTypes::*;
#(
  parameter int N_CHAN     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_CHAN-1:0]             has_event,
  input  logic [N_CHAN-1:0][31:0]       timestamp,
  input  logic [N_CHAN-1:0][31:0]       tot,
  output logic [N_CHAN-1:0]             clear,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output tdc_event_t                    evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef TDC_COLLECTOR_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cnt
`endif
);

  localparam int IW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

  collector_state_e   state_q;
  logic [IW-1:0]      rr_ptr_q;
  logic [N_CHAN-1:0]  clear_q;

  logic               req_found;
  logic [IW-1:0]      grant_sel;
  logic [IW-1:0]      rr_next;
  logic [N_CHAN-1:0]  grant_oh;
  logic               do_grant;
  logic               fifo_full;
  logic               fifo_empty;
  tdc_event_t         push_dat;

  // Cyclic search for the first requester at or after rr_ptr_q.
  always_comb begin
    logic [IW-1:0] idx;
    req_found = 1'b0;
    grant_sel = '0;
    idx       = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      idx = IW'((int'(rr_ptr_q) + i) % N_CHAN);
      if (!req_found && has_event[idx]) begin
        req_found = 1'b1;
        grant_sel = idx;
      end
    end
  end

  // Pointer advance past the winner, and the winner as a one-hot clear vector.
  always_comb begin
    rr_next  = (grant_sel == IW'(N_CHAN - 1)) ? '0 : grant_sel + IW'(1);
    grant_oh = '0;
    grant_oh[grant_sel] = 1'b1;
  end

  // Data is captured in IDLE only: clear zeroes the TDC's fields asynchronously.
  assign do_grant = (state_q == IDLE) && req_found && !fifo_full;
  assign push_dat = make_event(TDC_CHANNEL'(grant_sel), timestamp[grant_sel], tot[grant_sel]);

  // Arbiter FSM; clear_q doubles as the latched grant index (one-hot) for the CLEAR cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      clear_q  <= '1;
    end else begin
      clear_q <= '0;
      case (state_q)
        IDLE: begin
          if (do_grant) begin
            rr_ptr_q <= rr_next;
            clear_q  <= grant_oh;
            state_q  <= CLEAR;
          end
        end
        CLEAR:   state_q <= SETTLE;
        SETTLE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clear = clear_q;

  tdc_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (tdc_event_t)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (do_grant),
    .push_dat_i (push_dat),
    .pop_i      (evt_ready),
    .pop_dat_o  (evt_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign evt_valid = !fifo_empty;

`ifdef TDC_COLLECTOR_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count cycles where an event is waiting but the FIFO refuses it; saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if ((|has_event) && fifo_full && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tdc_event_collector.sv
// Directed self-checking bench for tdc_event_collector with a small TDC channel model.
// Latency: n/a.
// Backpressure: drives evt_ready low/high to exercise FIFO full and stall hold.
`timescale 1ns/1ps
module tb_tdc_event_collector;
  import TDCTypes::*;

  localparam int N_CHAN     = 4;
  localparam int FIFO_DEPTH = 16;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [N_CHAN-1:0]       has_event = '0;
  logic [N_CHAN-1:0][31:0] timestamp = '0;
  logic [N_CHAN-1:0][31:0] tot = '0;
  logic [N_CHAN-1:0]       clear;
  logic                    evt_valid;
  logic                    evt_ready = 1'b0;
  tdc_event_t              evt_data;
  logic [4:0]              fifo_level;
`ifdef TDC_COLLECTOR_STALL_CNT_EN
  logic [31:0]             stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Events waiting to be raised by a TDC channel once it is free (re-armed).
  typedef struct {
    logic [1:0]  ch;
    logic [31:0] ts;
    logic [31:0] tt;
  } pend_t;
  pend_t pend[$];

  // Single-event vectors with hand-computed expected event words.
  typedef struct {
    logic [1:0]  ch;
    logic [31:0] ts;
    logic [31:0] tt;
    logic [67:0] exp_data;
    logic [3:0]  exp_clear;
  } vec_t;
  vec_t vecs[4];

  tdc_event_collector #(
    .N_CHAN     (N_CHAN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .has_event  (has_event),
    .timestamp  (timestamp),
    .tot        (tot),
    .clear      (clear),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .fifo_level (fifo_level)
`ifdef TDC_COLLECTOR_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Raise pending events on free channels, keeping per-channel order.
  task automatic load_tdcs();
    int i = 0;
    while (i < pend.size()) begin
      if (!has_event[pend[i].ch]) begin
        has_event[pend[i].ch] = 1'b1;
        timestamp[pend[i].ch] = pend[i].ts;
        tot[pend[i].ch]       = pend[i].tt;
        pend.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  // One clock: sample point is 1ns after the edge; TDCs react to clear there.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < N_CHAN; c++) begin
      if (clear[c]) begin
        has_event[c] = 1'b0;
        timestamp[c] = '0;
        tot[c]       = '0;
      end
    end
    load_tdcs();
  endtask

  task automatic add_event(input logic [1:0] ch, input logic [31:0] ts, input logic [31:0] tt);
    pend_t p;
    p.ch = ch;
    p.ts = ts;
    p.tt = tt;
    pend.push_back(p);
  endtask

  task automatic do_reset();
    pend.delete();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int         waited;
    int         got;
    int         seen_ch[4];
    int         seen_t[4];
    logic [3:0] clr_acc;
    tdc_event_t exp_ev;

    vecs[0] = '{ch: 2'd2, ts: 32'd25505,      tt: 32'd199099,      exp_data: 68'h2_0000_63A1_0003_09BB, exp_clear: 4'b0100};
    vecs[1] = '{ch: 2'd0, ts: 32'hFFFF_FFFF,  tt: 32'h0000_0001,   exp_data: 68'h0_FFFF_FFFF_0000_0001, exp_clear: 4'b0001};
    vecs[2] = '{ch: 2'd3, ts: 32'h8000_0000,  tt: 32'hDEAD_BEEF,   exp_data: 68'h3_8000_0000_DEAD_BEEF, exp_clear: 4'b1000};
    vecs[3] = '{ch: 2'd1, ts: 32'h1234_5678,  tt: 32'h0000_00FF,   exp_data: 68'h1_1234_5678_0000_00FF, exp_clear: 4'b0010};

    // Reset: clear all ones while held, evt outputs idle.
    reset_n = 1'b0;
    repeat (3) tick();
    check("reset_clear", clear, 4'hF);
    check("reset_valid", evt_valid, 1'b0);
    check("reset_level", fifo_level, 5'd0);
    check("reset_data", evt_data, 68'h0);
    reset_n = 1'b1;
    tick();
    check("reset_release_clear", clear, 4'h0);

    // Single events from the table.
    evt_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      add_event(vecs[v].ch, vecs[v].ts, vecs[v].tt);
      load_tdcs();
      waited = 0;
      while (!evt_valid && waited < 8) begin
        tick();
        waited++;
      end
      check($sformatf("vec%0d_latency", v), waited, 1);
      check($sformatf("vec%0d_data", v), evt_data, vecs[v].exp_data);
      check($sformatf("vec%0d_clear", v), clear, vecs[v].exp_clear);
      tick();
      check($sformatf("vec%0d_clear_drop", v), clear, 4'h0);
      check($sformatf("vec%0d_popped", v), evt_valid, 1'b0);
      repeat (2) tick();
    end

    // Contention: all channels at once from rr_ptr = 0.
    do_reset();
    for (int c = 0; c < 4; c++) add_event(2'(c), 32'(100 + c), 32'(200 + c));
    load_tdcs();
    evt_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (evt_valid && got < 4) begin
        seen_ch[got] = int'(evt_data.chan);
        seen_t[got]  = t;
        check($sformatf("cont_ts%0d", got), evt_data.timestamp, 32'(100 + got));
        got++;
      end
    end
    check("cont_count", got, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got) check($sformatf("cont_order%0d", k), seen_ch[k], k);
      if (k > 0 && k < got) check($sformatf("cont_spacing%0d", k), seen_t[k] - seen_t[k-1], 3);
    end

    // Backpressure: 20 events, consumer stalled, FIFO fills to 16.
    do_reset();
    evt_ready = 1'b0;
    for (int k = 0; k < 20; k++) add_event(2'(k % 4), 32'(1000 + k), 32'(2000 + k));
    load_tdcs();
    repeat (60) tick();
    check("bp_level_full", fifo_level, 5'd16);
    check("bp_17th_pending", has_event[0], 1'b1);
    exp_ev = make_event(4'd0, 32'd1000, 32'd2000);
    clr_acc = '0;
    for (int t = 0; t < 8; t++) begin
      tick();
      clr_acc = clr_acc | clear;
      check($sformatf("bp_hold_data%0d", t), evt_data, exp_ev);
      check($sformatf("bp_hold_valid%0d", t), evt_valid, 1'b1);
    end
    check("bp_no_clear_when_full", clr_acc, 4'h0);
`ifdef TDC_COLLECTOR_STALL_CNT_EN
    check("bp_stall_cnt_nonzero", (stall_cnt != 32'd0), 1'b1);
`endif
    evt_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 200 && got < 20; t++) begin
      if (evt_valid) begin
        exp_ev = make_event(4'(got % 4), 32'(1000 + got), 32'(2000 + got));
        check($sformatf("bp_drain%0d", got), evt_data, exp_ev);
        got++;
      end
      tick();
    end
    check("bp_drain_count", got, 20);

    // Reset asserted during CLEAR with 5 events queued.
    evt_ready = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 5; k++) add_event(2'(k % 4), 32'(500 + k), 32'(600 + k));
    load_tdcs();
    waited = 0;
    while (!(fifo_level == 5'd5 && clear != 4'h0) && waited < 40) begin
      tick();
      waited++;
    end
    check("mid_reach_clear", (waited < 40), 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_level", fifo_level, 5'd0);
    check("mid_valid", evt_valid, 1'b0);
    check("mid_clear", clear, 4'hF);
    check("mid_data", evt_data, 68'h0);
    pend.delete();
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_release_clear", clear, 4'h0);
    check("mid_release_level", fifo_level, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_event_collector.md
# tdc_event_collector

Downstream consumer of the per-channel TDC blocks. It scans the `hasEvent` flags of `N_CHAN` TDC channels with a round-robin arbiter and captures each pending event as `{chan, timestamp, timeOverThreshold}`. It then pulses that channel's `clear` to re-arm it and buffers the event in a FIFO. The FIFO drains to the readout/DAQ side through a valid/ready stream.

## Interface
Parameters:
- `N_CHAN`, default 4: number of TDC channels served, 1..16.
- `FIFO_DEPTH`, default 16: event FIFO depth; must be a power of two, ≥2.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `has_event`, input, `[N_CHAN]`: per-channel `hasEvent` from each TDC.
- `timestamp`, input, `[N_CHAN][32]`: per-channel `timestamp`.
- `tot`, input, `[N_CHAN][32]`: per-channel `timeOverThreshold`.
- `clear`, output, `[N_CHAN]`: per-channel `clear` to each TDC; one-cycle pulse.
- `evt_valid`, output, 1: head-of-FIFO event available.
- `evt_ready`, input, 1: consumer accepts the event.
- `evt_data`, output, `tdc_event_t` (`TDC_CHAN_W`+64): `{chan, timestamp, tot}`.
- `fifo_level`, output, `$clog2(FIFO_DEPTH)+1`: current occupancy.

## Operation
- FSM states: `IDLE`, `CLEAR`, `SETTLE`.
- `IDLE`:
  - If any `has_event` bit is set and the FIFO is not full, grant the lowest-index requester at or after `rr_ptr`, searching cyclically.
  - On that edge: write the granted channel's event into the FIFO, latch `grant_idx`, set `rr_ptr` = `grant_idx`+1 mod `N_CHAN`, and go to `CLEAR`.
- `CLEAR`: drive `clear[grant_idx]` = 1 for exactly this cycle, then go to `SETTLE`.
- `SETTLE`: one dead cycle so the TDC's flag has dropped before re-arbitration; go to `IDLE`.
- The TDC's `clear` is edge-asynchronous and zeroes `timestamp`/`tot`. Data is therefore sampled in `IDLE`, never in or after `CLEAR`.
- FIFO full: no grant. Events stay pending in the TDCs (natural backpressure) and are never dropped by this block.
- Event word: `chan` = grant index cast to `TDC_CHANNEL`; 32-bit fields are passed through unmodified.
- FIFO: first-word fall-through. A pop occurs when `evt_valid` and `evt_ready` are both high. Push and pop in the same cycle are both performed, with level unchanged.
- Pointers wrap modulo `FIFO_DEPTH`; `fifo_level` distinguishes full from empty.

## Timing
Reset values:
- `clear` = all ones while `reset_n` is low. This re-arms every TDC. It deasserts at the first `clk` edge after `reset_n` rises.
- `evt_valid` = 0; `fifo_level` = 0; `evt_data` = 0.
- FSM = `IDLE`; `rr_ptr` = 0.

Latency and throughput:
- `has_event` high in `IDLE` (edge T) → `evt_valid` high after edge T, if the FIFO was empty.
- `clear` pulse is high from T to T+1.
- Throughput: at most one event per 3 cycles.
- `evt_valid` must not drop and `evt_data` must not change while `evt_valid` is high and `evt_ready` is low.

Boundary conditions:
- Simultaneous requests: round-robin guarantees each pending channel is served within `N_CHAN` grants.
- Reset asserted mid-operation (any state): FIFO contents are discarded and all outputs return to their reset values immediately.
- `has_event` for a channel other than the granted one during `CLEAR`/`SETTLE`: held pending and arbitrated at the next `IDLE`.

## Configuration
- Macro: `TDC_COLLECTOR_STALL_CNT_EN`.
- Defined: adds output port `stall_cnt` [32]. It increments every cycle in which any `has_event` is high and the FIFO is full, saturates at `32'hFFFF_FFFF`, and resets to 0.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Package `TDCTypes`:
  - existing `TDC_CHANNEL`;
  - add `TDC_CHAN_W`;
  - add `tdc_event_t` packed struct `{TDC_CHANNEL chan; logic [31:0] timestamp; logic [31:0] tot;}`.
- Sub-module `tdc_event_fifo`: parameterised on `FIFO_DEPTH` and the element type; provides push/pop, full/empty and level.
- The arbiter and FSM live in `tdc_event_collector`.

## Test plan
- Reset: hold `reset_n` low for 3 cycles. Expect `clear` = all ones, then all zeros one edge after release. Expect `evt_valid` = 0 and `fifo_level` = 0.
- Single event: ch2, `timestamp` = 25505, `tot` = 199099, `evt_ready` = 1.
  - Expect `evt_data` = {2, 25505, 199099} after one edge.
  - Expect `clear[2]` pulsed exactly one cycle, and no other `clear` bit asserted.
- Contention: all 4 channels set simultaneously, `rr_ptr` = 0. Expect output order ch0, ch1, ch2, ch3, with events 3 cycles apart.
- Backpressure: `evt_ready` = 0, 20 events injected, `FIFO_DEPTH` = 16.
  - Expect `fifo_level` = 16, the 17th event still pending in its TDC, and no clear for it.
  - With the macro defined, expect `stall_cnt` > 0.
  - After releasing `evt_ready`, expect all 20 events in order, with `evt_data` stable during the stall.
- Reset mid-operation: assert `reset_n` low during `CLEAR` with 5 events queued. Expect `fifo_level` = 0 and `evt_valid` = 0 immediately, and `clear` = all ones.
